// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and constants for the binary-to-BCD display converter
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_e;

  localparam int         DISP_MAX   = 9999;
  localparam logic [3:0] OVF_DIGIT  = 4'hE;
  localparam int         BCD_DIGITS = 4;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble correction: add 3 when the digit is 5 or more
module bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/bin2bcd_disp.sv
// rtl/bin2bcd_disp.sv - sequential double-dabble converter feeding the four-digit display scan stage
// Optional BIN2BCD_OVF_EN: values above 9999 show EEEE and raise ovf.
module bin2bcd_disp
  import bin2bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [BIN_WIDTH-1:0] bin_in,
  input  logic                 bin_valid,
  output logic                 bin_ready,
  output logic [3:0]           data_disp_3,
  output logic [3:0]           data_disp_2,
  output logic [3:0]           data_disp_1,
  output logic [3:0]           data_disp_0,
  output logic                 done,
  output logic                 ovf
);

  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam int SW = 4 * BCD_DIGITS;

  state_e               state_q;
  logic [BIN_WIDTH-1:0] shift_q;
  logic [SW-1:0]        scratch_q;
  logic [SW-1:0]        scratch_d;
  logic [SW-1:0]        corr;
  logic [CW-1:0]        cnt_q;
  logic [SW-1:0]        digits_q;
  logic                 done_q;
  logic [SW-1:0]        result;
  logic                 carry_unused;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_i(scratch_q[4*i +: 4]),
      .nib_o(corr[4*i +: 4])
    );
  end

  // Carry out of the thousands nibble falls off, giving value mod 10000.
  assign scratch_d    = {corr[SW-2:0], shift_q[BIN_WIDTH-1]};
  assign carry_unused = corr[SW-1];

`ifdef BIN2BCD_OVF_EN
  logic ovf_flag_q;
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (RST) begin
      ovf_flag_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (state_q == IDLE && bin_valid) begin
      ovf_flag_q <= (32'(bin_in) > 32'(DISP_MAX));
    end else if (state_q == UPDATE) begin
      ovf_q <= ovf_flag_q;
    end
  end

  assign result = ovf_flag_q ? {BCD_DIGITS{OVF_DIGIT}} : scratch_q;
  assign ovf    = ovf_q;
`else
  assign result = scratch_q;
  assign ovf    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bin_valid) begin
            shift_q   <= bin_in;
            scratch_q <= '0;
            cnt_q     <= CW'(BIN_WIDTH);
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_q << 1;
          cnt_q     <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= UPDATE;
          end
        end
        UPDATE: begin
          digits_q <= result;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bin_ready   = (state_q == IDLE);
  assign data_disp_3 = digits_q[15:12];
  assign data_disp_2 = digits_q[11:8];
  assign data_disp_1 = digits_q[7:4];
  assign data_disp_0 = digits_q[3:0];
  assign done        = done_q;

endmodule

// File: tb/tb_bin2bcd_disp.sv
// tb/tb_bin2bcd_disp.sv - randomized self-checking bench with a cycle-level behavioural model
module tb_bin2bcd_disp;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] bin;
  logic         valid;
  logic         ready;
  logic [3:0]   d3, d2, d1, d0;
  logic         done;
  logic         ovf;

  logic         rst4;
  logic [3:0]   bin4;
  logic         valid4;
  logic         ready4;
  logic [3:0]   e3, e2, e1, e0;
  logic         done4;
  logic         ovf4;

  always #5 clk = ~clk;

  bin2bcd_disp #(.BIN_WIDTH(W)) dut (
    .clk(clk), .RST(rst), .bin_in(bin), .bin_valid(valid), .bin_ready(ready),
    .data_disp_3(d3), .data_disp_2(d2), .data_disp_1(d1), .data_disp_0(d0),
    .done(done), .ovf(ovf)
  );

  bin2bcd_disp #(.BIN_WIDTH(4)) dut4 (
    .clk(clk), .RST(rst4), .bin_in(bin4), .bin_valid(valid4), .bin_ready(ready4),
    .data_disp_3(e3), .data_disp_2(e2), .data_disp_1(e1), .data_disp_0(e0),
    .done(done4), .ovf(ovf4)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp_disp(input int v);
    int m;
    m = v % 10000;
`ifdef BIN2BCD_OVF_EN
    if (v > 9999) return 16'hEEEE;
`endif
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic exp_ovf(input int v);
`ifdef BIN2BCD_OVF_EN
    return v > 9999;
`else
    return (v < 0);
`endif
  endfunction

  // Model: a captured value appears W+1 edges after its handshake; ready returns on that edge.
  int          done_at = -1;
  int          pend    = 0;
  logic [15:0] m_disp  = 16'h0;
  logic        m_ovf   = 1'b0;
  logic        m_ready = 1'b1;
  logic        m_done  = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    m_done = 1'b0;
    if (rst) begin
      m_disp  = 16'h0;
      m_ovf   = 1'b0;
      m_ready = 1'b1;
      done_at = -1;
    end else if (cyc == done_at) begin
      m_disp  = exp_disp(pend);
      m_ovf   = exp_ovf(pend);
      m_done  = 1'b1;
      m_ready = 1'b1;
      done_at = -1;
    end else if (m_ready && valid) begin
      pend    = int'(bin);
      done_at = cyc + W + 1;
      m_ready = 1'b0;
    end
  end

  always @(posedge clk) begin
    #2;
    chk("ready", ready, m_ready);
    chk("done", done, m_done);
    chk("digits", {d3, d2, d1, d0}, m_disp);
    chk("ovf", ovf, m_ovf);
  end

  task automatic send(input logic [W-1:0] v, output int hs);
    int k;
    k = 0;
    bin = v;
    valid = 1'b1;
    while (!ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("send_ready", ready, 1'b1);
    hs = cyc + 1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 40);
    chk("done_seen", done, 1'b1);
    dc = cyc;
  endtask

  int hs, hs2, dc, cap, seen;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid = 1'b0; bin = '0;
    rst4 = 1'b1; valid4 = 1'b0; bin4 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; rst4 = 1'b0;
    chk("rst_digits", {d3, d2, d1, d0}, 16'h0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", ovf, 1'b0);

    send(14'd1234, hs);
    wait_done(dc);
    chk("lat_1234", dc - hs, 15);
    chk("dig_1234", {d3, d2, d1, d0}, 16'h1234);
    chk("ready_after_done", ready, 1'b1);

    send(14'd0, hs);
    wait_done(dc);
    chk("dig_0", {d3, d2, d1, d0}, 16'h0000);
    send(14'd9999, hs2);
    chk("b2b_spacing", hs2 - hs, 16);
    wait_done(dc);
    chk("dig_9999", {d3, d2, d1, d0}, 16'h9999);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);

    send(14'd12345, hs);
    wait_done(dc);
`ifdef BIN2BCD_OVF_EN
    chk("dig_12345", {d3, d2, d1, d0}, 16'hEEEE);
    chk("ovf_12345", ovf, 1'b1);
`else
    chk("dig_12345", {d3, d2, d1, d0}, 16'h2345);
    chk("ovf_12345", ovf, 1'b0);
`endif
    send(14'd42, hs);
    wait_done(dc);
    chk("dig_42", {d3, d2, d1, d0}, 16'h0042);
    chk("ovf_42", ovf, 1'b0);

    @(negedge clk);
    chk("hold_start_ready", ready, 1'b1);
    bin = 14'd500;
    valid = 1'b1;
    cap = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) chk("dig_500", {d3, d2, d1, d0}, 16'h0500);
      bin = W'($urandom_range(0, 16383));
      if (ready) begin
        cap = int'(bin);
        break;
      end
    end
    chk("hold_recaptured", ready, 1'b1);
    @(negedge clk);
    valid = 1'b0;
    wait_done(dc);
    chk("dig_hold_next", {d3, d2, d1, d0}, exp_disp(cap));

    send(14'd8765, hs);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_digits", {d3, d2, d1, d0}, 16'h0);
    chk("abort_ready", ready, 1'b1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    send(14'd8765, hs);
    wait_done(dc);
    chk("dig_8765", {d3, d2, d1, d0}, 16'h8765);

    for (int i = 0; i < 300; i++) begin
      valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: bin = 14'd9999;
        1: bin = 14'd10000;
        2: bin = 14'd16383;
        default: bin = W'($urandom_range(0, 16383));
      endcase
      @(negedge clk);
    end
    valid = 1'b0;
    repeat (20) @(negedge clk);

    for (int v = 0; v < 16; v++) begin
      chk("w4_ready", ready4, 1'b1);
      bin4 = 4'(v);
      valid4 = 1'b1;
      hs = cyc + 1;
      @(negedge clk);
      valid4 = 1'b0;
      bin4 = 4'($urandom_range(0, 15));
      for (int k = 0; k < 20 && !done4; k++) @(negedge clk);
      chk("w4_done", done4, 1'b1);
      chk("w4_lat", cyc - hs, 5);
      chk("w4_digits", {e3, e2, e1, e0}, {8'h00, 4'(v / 10), 4'(v % 10)});
      chk("w4_ovf", ovf4, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
